// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt capture block.
package irq_pkg;
  localparam int N_IRQ = 8;
  localparam int IDX_W = $clog2(N_IRQ);

  typedef enum logic {
    IDLE,
    PRESENT
  } irq_state_t;
endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: the highest set bit wins; an all-zero input
// gives any=0 and idx=0.
module prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     in,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) idx = IDX_W'(i);
    end
  end

  assign any = |in;

endmodule

// File: rtl/irq_capture.sv
// Captures request rising edges into sticky pending bits and presents the
// highest-index unmasked pending request over a valid/ready handshake.
module irq_capture
  import irq_pkg::*;
#(
  parameter int N     = N_IRQ,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  output logic             idx_valid,
  output logic [IDX_W-1:0] idx_out,
  input  logic             idx_ready,
  output logic [N-1:0]     pending,
  output logic             ovf,
  input  logic             ovf_clr
);

  irq_state_t       state, state_nxt;
  logic [N-1:0]     req_q;
  logic             armed;
  logic [N-1:0]     rise;
  logic [N-1:0]     clr;
  logic             handshake;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic             idx_valid_nxt;
  logic [IDX_W-1:0] idx_out_nxt;

  // armed stays low for the first cycle after reset so a line already high at
  // release is only seen as an edge after it falls and rises again.
  assign rise      = armed ? (req_in & ~req_q) : '0;
  assign handshake = idx_valid & idx_ready;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = handshake && (idx_out == IDX_W'(i));
    end
  end

  prio_enc #(.N(N), .IDX_W(IDX_W)) u_prio_enc (
    .in  (pending & mask),
    .any (sel_any),
    .idx (sel_idx)
  );

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      armed   <= 1'b0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      req_q   <= req_in;
      armed   <= 1'b1;
      pending <= rise | (pending & ~clr);
      // A fresh overflow outranks a clear request in the same cycle.
      if (|(rise & pending & ~clr)) ovf <= 1'b1;
      else if (ovf_clr)             ovf <= 1'b0;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_valid_nxt = idx_valid;
    idx_out_nxt   = idx_out;
    case (state)
      IDLE: begin
        if (sel_any) begin
          idx_out_nxt   = sel_idx;
          idx_valid_nxt = 1'b1;
          state_nxt     = PRESENT;
        end
      end
      PRESENT: begin
        // Presented index is never retracted; only a handshake releases it.
        if (handshake) begin
          idx_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        idx_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx_valid <= 1'b0;
      idx_out   <= '0;
    end else begin
      state     <= state_nxt;
      idx_valid <= idx_valid_nxt;
      idx_out   <= idx_out_nxt;
    end
  end

endmodule

// File: tb/tb_irq_capture.sv
// Directed self-checking bench for irq_capture with hand-computed expectations.
module tb_irq_capture;
  import irq_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       req_in;
  logic [7:0]       mask;
  logic             idx_valid;
  logic [IDX_W-1:0] idx_out;
  logic             idx_ready;
  logic [7:0]       pending;
  logic             ovf;
  logic             ovf_clr;

  int passed = 0;
  int total  = 0;

  irq_capture #(.N(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .idx_valid (idx_valid),
    .idx_out   (idx_out),
    .idx_ready (idx_ready),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_in = '0; mask = 8'hFF; idx_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    check("rst_valid",   32'(idx_valid), 32'h0);
    check("rst_idx",     32'(idx_out),   32'h0);
    check("rst_pending", 32'(pending),   32'h0);
    check("rst_ovf",     32'(ovf),       32'h0);
    rst = 1'b0;
    step();

    // Single rise on line 5: pending at t+1, presented at t+2, cleared at t+3.
    req_in = 8'h20; idx_ready = 1'b1;
    step();
    check("t1_pending",  32'(pending),   32'h20);
    check("t1_valid_lo", 32'(idx_valid), 32'h0);
    step();
    check("t1_valid",    32'(idx_valid), 32'h1);
    check("t1_idx",      32'(idx_out),   32'h5);
    step();
    check("t1_cleared",  32'(pending),   32'h00);
    check("t1_drop",     32'(idx_valid), 32'h0);
    idx_ready = 1'b0; req_in = '0;
    step();

    // Two simultaneous rises; index 7 held under changing mask, then 1 after a bubble.
    req_in = 8'h82;
    step();
    check("t2_pending", 32'(pending), 32'h82);
    step();
    check("t2_idx7", 32'(idx_out), 32'h7);
    mask = 8'h00;
    step(); step(); step();
    check("t2_hold_valid", 32'(idx_valid), 32'h1);
    check("t2_hold_idx",   32'(idx_out),   32'h7);
    mask = 8'hFF; idx_ready = 1'b1;
    step();
    check("t2_bubble",     32'(idx_valid), 32'h0);
    check("t2_pend_after", 32'(pending),   32'h02);
    step();
    check("t2_valid1", 32'(idx_valid), 32'h1);
    check("t2_idx1",   32'(idx_out),   32'h1);
    step();
    check("t2_pend_zero", 32'(pending), 32'h00);
    idx_ready = 1'b0; req_in = '0;
    step();

    // Masked pending line waits, then is selected the cycle after its mask sets.
    mask = 8'hFD; req_in = 8'h02;
    step();
    check("t3_pending", 32'(pending), 32'h02);
    step(); step();
    check("t3_masked_valid", 32'(idx_valid), 32'h0);
    mask = 8'hFF;
    step();
    check("t3_valid", 32'(idx_valid), 32'h1);
    check("t3_idx",   32'(idx_out),   32'h1);
    idx_ready = 1'b1;
    step();
    check("t3_cleared", 32'(pending), 32'h00);
    idx_ready = 1'b0; req_in = '0;
    step();

    // Second rise on already-pending line 3 flags overflow; one grant clears it.
    req_in = 8'h08;
    step();
    req_in = 8'h00;
    step();
    check("t4_idx3", 32'(idx_out), 32'h3);
    req_in = 8'h08;
    step();
    check("t4_ovf_set",  32'(ovf),     32'h1);
    check("t4_pend_one", 32'(pending), 32'h08);
    ovf_clr = 1'b1;
    step();
    check("t4_ovf_clr", 32'(ovf), 32'h0);
    ovf_clr = 1'b0; idx_ready = 1'b1;
    step();
    check("t4_pend_clr", 32'(pending),   32'h00);
    check("t4_drop",     32'(idx_valid), 32'h0);
    step();
    check("t4_no_regrant", 32'(idx_valid), 32'h0);
    idx_ready = 1'b0; req_in = '0;
    step();

    // Grant of 4 collides with a new rise on 4: pending survives, no overflow.
    req_in = 8'h10;
    step();
    req_in = 8'h00;
    step();
    check("t5_idx4", 32'(idx_out), 32'h4);
    idx_ready = 1'b1; req_in = 8'h10;
    step();
    check("t5_pend_kept", 32'(pending),   32'h10);
    check("t5_ovf_zero",  32'(ovf),       32'h0);
    check("t5_bubble",    32'(idx_valid), 32'h0);
    step();
    check("t5_regrant_valid", 32'(idx_valid), 32'h1);
    check("t5_regrant_idx",   32'(idx_out),   32'h4);
    step();
    check("t5_pend_zero", 32'(pending), 32'h00);
    idx_ready = 1'b0; req_in = '0;
    step();

    // Asynchronous reset while presenting 6; held-high lines are not edges after release.
    req_in = 8'h41;
    step();
    step();
    check("t6_idx6", 32'(idx_out), 32'h6);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid",   32'(idx_valid), 32'h0);
    check("t6_rst_pending", 32'(pending),   32'h00);
    idx_ready = 1'b1;
    step();
    rst = 1'b0;
    step(); step(); step();
    check("t6_no_edge_pend",  32'(pending),   32'h00);
    check("t6_no_edge_valid", 32'(idx_valid), 32'h0);
    req_in = 8'h00;
    step();
    req_in = 8'h01;
    step();
    check("t6_idx0_pending", 32'(pending), 32'h01);
    step();
    check("t6_idx0_valid", 32'(idx_valid), 32'h1);
    check("t6_idx0",       32'(idx_out),   32'h0);
    step();
    check("t6_idx0_drop", 32'(idx_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
